multimode_counter: RTL
======================

// Module: multimode_counter
// PURPOSE
//  Parametrised successor to the 3-bit mode counter: WIDTH-bit sequence generator with four step modes.
//  Modes are binary up, binary down, Gray up and maximal-length LFSR, plus synchronous load and a wrap pulse.
//  A 3-state run/pause FSM gates stepping. Drives stimulus/address sequences in lab designs; probed via UUT.state/next_state.
// PARAMETERS
//  WIDTH  3  counter width in bits; legal 3..8 (LFSR tap table bound); elaboration error outside range
// PORTS
//  clk         in   1      rising-edge clock; single clock domain
//  reset       in   1      synchronous, active-high; sampled on rising clk
//  enable      in   1      request to run; level-sensitive
//  mode        in   2      00 bin up, 01 bin down, 10 Gray up, 11 LFSR
//  load        in   1      synchronous load strobe
//  load_value  in   WIDTH  value loaded on load
//  count       out  WIDTH  current sequence value (registered)
//  wrap        out  1      registered 1-cycle pulse, asserted on the edge count returns to sequence origin
//  running     out  1      1 when state==RUN (registered)
// BEHAVIOUR
//  Reset: count=0, wrap=0, running=0, state=IDLE; reset overrides all inputs on the same edge.
//  FSM (2-bit encoding IDLE=00, RUN=01, PAUSE=10; 11 illegal -> IDLE):
//   IDLE --enable--> RUN; RUN --!enable--> PAUSE; PAUSE --enable--> RUN; otherwise hold.
//  Step rule: count advances only on edges where state==RUN && enable==1.
//   Start latency: enable rising in IDLE/PAUSE moves FSM to RUN on edge 1; first step on edge 2.
//   Enable falling in RUN: no step on that edge; FSM -> PAUSE; count holds.
//  Priority per edge: reset > load > step. load: count<=load_value, wrap<=0, state unchanged, no step.
//  Next-value per mode (evaluated from current count; mode change takes effect on the next step, no resync):
//   bin up:   count+1 mod 2^WIDTH; wrap when next==0
//   bin down: count-1 mod 2^WIDTH; wrap when next==2^WIDTH-1
//   Gray up:  gray(bin(count)+1), bin() = Gray-to-binary decode; wrap when next==0
//   LFSR:     Fibonacci shift-left, next={count[W-2:0],fb}, fb = XOR of package taps (WIDTH=3: q[2]^q[1])
//             count==0 (lock-up) steps to 1 with no wrap; otherwise wrap when next==1
//  wrap is 0 on every edge without a step. A Gray-mode step from a non-Gray-aligned value after a mode switch is legal.
// CONFIGURATION
//  Macro MULTIMODE_COUNTER_SATURATE_EN:
//   defined:     bin up holds at 2^WIDTH-1; bin down holds at 0; wrap never asserts in binary modes.
//                FSM stays RUN while saturated. Gray/LFSR unaffected.
//   not defined: binary modes wrap modulo 2^WIDTH with the wrap pulse as above.
// STRUCTURE
//  Package multimode_counter_pkg: mode constants (MODE_UP/DOWN/GRAY/LFSR), state encodings (S_IDLE/RUN/PAUSE),
//   LFSR tap-mask function lfsr_taps(width) for widths 3..8.
//  Sub-module multimode_counter_next: combinational next-value + wrap-detect (inputs count, mode; outputs next, wrap_n).
//  Top holds FSM, priority mux and output registers.
// TESTING (WIDTH=3)
//  1 reset=1 for 5 cycles, enable=1 mid-reset -> count=0, wrap=0, running=0, state=IDLE throughout.
//  2 mode=00, enable=1 from IDLE -> running=1 on edge 1; count 0->1 on edge 2; ...7->0 with wrap=1 that edge only.
//  3 mode=10 continuous run from 0 -> 0,1,3,2,6,7,5,4,0; wrap pulses once, on the edge 4->0.
//  4 mode=11 from count 0 -> 1 (no wrap),2,5,3,7,6,4,1 (wrap=1); period 7, never 0.
//  5 mode=01 from 0 with enable toggled 0 for 2 cycles -> 0->7 (wrap), PAUSE holds 7; resume 1 edge of latency, then 6.
//  6 load=1,load_value=5 with enable=1 in RUN -> count=5, no step, wrap=0; reset asserted mid-run -> count=0, IDLE.
//    With SATURATE_EN, mode=00 from 6 -> 7,7,7; wrap stays 0.

Source files
------------

// File: rtl/multimode_counter_pkg.sv
// ============================================================================
// Module : multimode_counter_pkg
// Brief  : Mode codes, FSM state encoding and LFSR tap table for multimode_counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package multimode_counter_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_LFSR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  // Maximal-length feedback taps; bit k set means q[k] joins the XOR.
  function automatic logic [7:0] lfsr_taps(input int width);
    case (width)
      3:       return 8'h06;
      4:       return 8'h0C;
      5:       return 8'h14;
      6:       return 8'h30;
      7:       return 8'h60;
      8:       return 8'hB8;
      default: return 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multimode_counter_next.sv
// ============================================================================
// Module : multimode_counter_next
// Brief  : Combinational next-value and wrap detect for all four step modes.
//          MULTIMODE_COUNTER_SATURATE_EN makes the binary modes saturate.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multimode_counter_next
  import multimode_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] count,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next,
  output logic             wrap_n
);

  localparam logic [7:0]       TAPS     = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX      = '1;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] bin_inc;
  assign bin_inc = gray2bin(count) + ONE;

  always_comb begin
    next   = count;
    wrap_n = 1'b0;
    case (mode)
      MODE_UP: begin
`ifdef MULTIMODE_COUNTER_SATURATE_EN
        next = (count == MAX) ? count : count + ONE;
`else
        next   = count + ONE;
        wrap_n = (next == ZERO);
`endif
      end
      MODE_DOWN: begin
`ifdef MULTIMODE_COUNTER_SATURATE_EN
        next = (count == ZERO) ? count : count - ONE;
`else
        next   = count - ONE;
        wrap_n = (next == MAX);
`endif
      end
      MODE_GRAY: begin
        next   = bin_inc ^ (bin_inc >> 1);
        wrap_n = (next == ZERO);
      end
      MODE_LFSR: begin
        // All-zero is the LFSR lock-up state; kick it back into the sequence.
        if (count == ZERO) begin
          next = ONE;
        end else begin
          next   = {count[WIDTH-2:0], ^(count & TAP_MASK)};
          wrap_n = (next == ONE);
        end
      end
      default: next = count;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multimode_counter.sv
// ============================================================================
// Module : multimode_counter
// Brief  : WIDTH-bit multimode sequence generator with run/pause FSM, load
//          and wrap pulse. Option macro: MULTIMODE_COUNTER_SATURATE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multimode_counter
  import multimode_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             running
);

  if (WIDTH < 3 || WIDTH > 8) begin : g_width_check
    $error("multimode_counter: WIDTH must be in 3..8");
  end

  state_e           state, next_state;
  logic [WIDTH-1:0] count_q, count_d, step_val;
  logic             wrap_q, wrap_d, step_wrap, running_q;
  logic             step;

  multimode_counter_next #(.WIDTH(WIDTH)) u_next (
    .count  (count_q),
    .mode   (mode),
    .next   (step_val),
    .wrap_n (step_wrap)
  );

  // A load edge freezes the FSM as well as suppressing the step.
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:  next_state = (load || !enable) ? S_IDLE : S_RUN;
      S_RUN:   next_state = (load || enable)  ? S_RUN  : S_PAUSE;
      S_PAUSE: next_state = (load || !enable) ? S_PAUSE : S_RUN;
      default: next_state = S_IDLE;
    endcase
  end

  assign step = (state == S_RUN) && enable;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (step) begin
      count_d = step_val;
      wrap_d  = step_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= next_state;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      running_q <= (next_state == S_RUN);
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign running = running_q;

endmodule

`default_nettype wire
